// File: rtl/ctrl_pkg.sv
// Shared controller definitions: instruction word layout and loader FSM encoding.
// Fields are packed LSB-first, last-stage flag in the MSB.
package ctrl_pkg;

    function automatic int unsigned instr_width(int unsigned vec_id_w, int unsigned rf_addr_w,
                                                int unsigned data_addr_w);
        return 2 + vec_id_w + 2 * rf_addr_w + 3 * data_addr_w;
    endfunction

    localparam int unsigned VEC_ID_WIDTH_DEF       = 3;
    localparam int unsigned REGFILE_ADDR_WIDTH_DEF = 3;
    localparam int unsigned DATA_ADDR_WIDTH_DEF    = 4;

    localparam int unsigned COEF_PTR_OFS   = 0;
    localparam int unsigned DATA_LPTR_OFS  = COEF_PTR_OFS + DATA_ADDR_WIDTH_DEF;
    localparam int unsigned DATA_UPTR_OFS  = DATA_LPTR_OFS + DATA_ADDR_WIDTH_DEF;
    localparam int unsigned ERR_LOGIC_OFS  = DATA_UPTR_OFS + DATA_ADDR_WIDTH_DEF;
    localparam int unsigned RES_LOGIC_OFS  = ERR_LOGIC_OFS + REGFILE_ADDR_WIDTH_DEF;
    localparam int unsigned VEC_ID_OFS     = RES_LOGIC_OFS + REGFILE_ADDR_WIDTH_DEF;
    localparam int unsigned UPSAMPLE_OFS   = VEC_ID_OFS + VEC_ID_WIDTH_DEF;
    localparam int unsigned LAST_STAGE_OFS = UPSAMPLE_OFS + 1;

    typedef enum logic [1:0] {
        LdIdle,
        LdLoad,
        LdDrain,
        LdDone
    } ld_state_e;

endpackage

// File: rtl/ctrl_imem_ram.sv
// Simple dual-port instruction RAM: synchronous write, registered read with enable.
module ctrl_imem_ram #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ctrl_imem_loader.sv
// Instruction store with a valid/ready program loader and a latency-1 fetch port.
module ctrl_imem_loader
    import ctrl_pkg::*;
#(
    parameter int unsigned VEC_ID_WIDTH       = 3,
    parameter int unsigned REGFILE_ADDR_WIDTH = 3,
    parameter int unsigned DATA_ADDR_WIDTH    = 4,
    parameter int unsigned INSTR_ADDR_WIDTH   = 4,
    localparam int unsigned INSTR_WIDTH =
        instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        prog,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [INSTR_WIDTH-1:0]      ld_data,
    input  logic                        ld_last,
    input  logic                        fetch,
    input  logic [INSTR_ADDR_WIDTH-1:0] pc,
    output logic [INSTR_WIDTH-1:0]      instr_word,
    output logic [INSTR_ADDR_WIDTH:0]   prog_len,
    output logic                        prog_valid,
    output logic                        prog_err,
    output logic                        fetch_oob
);

    localparam int unsigned DEPTH = 2 ** INSTR_ADDR_WIDTH;
    localparam int unsigned LW    = INSTR_ADDR_WIDTH + 1;

    ld_state_e               state_q, state_d;
    logic                    prog_q;
    logic [LW-1:0]           wptr_q, wptr_d, len_q, len_d;
    logic                    valid_q, valid_d, err_q, err_d, oob_q, oob_d;
    logic                    ready_q, ready_d, zero_q, zero_d;
    logic [INSTR_WIDTH-1:0]  ram_rdata;

    logic prog_rise, xfer, last_xfer, wptr_full, rd_en, rd_hit;

    assign prog_rise = prog & ~prog_q;
    assign xfer      = ld_valid & ready_q;
    assign last_xfer = xfer & ld_last;
    assign wptr_full = (wptr_q == LW'(DEPTH - 1));
    assign rd_en     = fetch & ~prog;
    assign rd_hit    = valid_q & ({1'b0, pc} < len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LdIdle;
            prog_q  <= 1'b0;
            wptr_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            oob_q   <= 1'b0;
            ready_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            prog_q  <= prog;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            oob_q   <= oob_d;
            ready_q <= ready_d;
            zero_q  <= zero_d;
        end
    end

    // A last transfer wins over prog falling in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LdIdle, LdDone: if (prog_rise) state_d = LdLoad;
            LdLoad: begin
                if (last_xfer)              state_d = LdDone;
                else if (!prog)             state_d = LdIdle;
                else if (xfer && wptr_full) state_d = LdDrain;
            end
            LdDrain: if (last_xfer || !prog) state_d = LdIdle;
            default: state_d = LdIdle;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        len_d   = len_q;
        valid_d = valid_q;
        err_d   = err_q;
        oob_d   = oob_q;
        zero_d  = zero_q;
        ready_d = (state_d == LdLoad) || (state_d == LdDrain);
        if (prog_rise) begin
            wptr_d  = '0;
            len_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
            oob_d   = 1'b0;
        end
        if (state_q == LdLoad) begin
            if (xfer) wptr_d = wptr_q + 1'b1;
            if (last_xfer) begin
                len_d   = wptr_q + 1'b1;
                valid_d = 1'b1;
            end else if (!prog || (xfer && wptr_full)) begin
                err_d = 1'b1;
            end
        end
        if (state_q == LdDrain && !last_xfer && !prog) err_d = 1'b1;
        if (rd_en) begin
            zero_d = ~rd_hit;
            if (!rd_hit) oob_d = 1'b1;
        end
    end

    ctrl_imem_ram #(
        .ADDR_WIDTH(INSTR_ADDR_WIDTH),
        .DATA_WIDTH(INSTR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   ((state_q == LdLoad) && xfer),
        .waddr(wptr_q[INSTR_ADDR_WIDTH-1:0]),
        .wdata(ld_data),
        .re   (rd_en && rd_hit),
        .raddr(pc),
        .rdata(ram_rdata)
    );

    assign ld_ready   = ready_q;
    assign instr_word = zero_q ? '0 : ram_rdata;
    assign prog_len   = len_q;
    assign prog_valid = valid_q;
    assign prog_err   = err_q;
    assign fetch_oob  = oob_q;

endmodule

// File: doc/ctrl_imem_loader.md
Name: ctrl_imem_loader

Overview:
Instruction store and program loader that answers the controller's fetch port (fetch/pc -> instr_word). While prog is high it accepts a valid/ready stream of instruction words from the host and writes them sequentially from address 0. In run mode it returns the addressed word one cycle after fetch. It also reports program length, completion and error status.

Parameters:
VEC_ID_WIDTH, 3, vector id field width in the instruction word
REGFILE_ADDR_WIDTH, 3, register-file address field width
DATA_ADDR_WIDTH, 4, data/coef pointer field width
INSTR_ADDR_WIDTH, 4, pc width; depth = 2**INSTR_ADDR_WIDTH
(derived) INSTR_WIDTH = 2 + VEC_ID_WIDTH + 2*REGFILE_ADDR_WIDTH + 3*DATA_ADDR_WIDTH (23 at defaults)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
prog  in  1  program mode; level; its rise starts a load
ld_valid  in  1  host word valid
ld_ready  out  1  loader accepts word
ld_data  in  INSTR_WIDTH  instruction word
ld_last  in  1  final word of program
fetch  in  1  read request from controller
pc  in  INSTR_ADDR_WIDTH  read address
instr_word  out  INSTR_WIDTH  registered read data
prog_len  out  INSTR_ADDR_WIDTH+1  number of stored words (0..depth)
prog_valid  out  1  a complete, error-free program is loaded
prog_err  out  1  sticky load error; cleared by next prog rise
fetch_oob  out  1  sticky: fetch with pc >= prog_len; cleared by prog rise

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low. Reset values: state IDLE, wptr 0, prog_len 0, prog_valid 0, prog_err 0, fetch_oob 0, instr_word 0, ld_ready 0. Memory contents are not reset.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE/DONE -> LOAD on prog rising edge (prog=1, prog_d=0). The same cycle clears wptr, prog_len, prog_valid, prog_err and fetch_oob.
  - LOAD: ld_ready=1. A transfer occurs when ld_valid&ld_ready; it writes mem[wptr]=ld_data and increments wptr.
  - LOAD, transfer with ld_last: prog_len <= wptr+1, prog_valid <= 1, go to DONE.
  - LOAD, transfer without ld_last while wptr == depth-1: the word is written, then prog_err <= 1, go to DRAIN. The overflow word is the (depth+1)-th word.
  - DRAIN: ld_ready=1 and words are discarded. A transfer with ld_last goes to IDLE. prog_valid stays 0 and prog_len stays 0.
  - LOAD or DRAIN with prog falling before ld_last: abort, prog_err <= 1, prog_valid 0, go to IDLE. If prog falls in the same cycle as a last transfer, the transfer completes normally.
  - A program of exactly depth words (ld_last on word depth) is legal: prog_len = depth, no error.
- ld_ready is registered from the next state. It is 0 in IDLE and DONE.
- Read port:
  - fetch=1 and prog=0: instr_word <= (pc < prog_len) ? mem[pc] : 0. The data is visible the cycle after fetch (latency 1).
  - With pc >= prog_len, or prog_valid=0, the all-zero word is returned and fetch_oob <= 1.
  - fetch=0, or prog=1: instr_word holds its value.
- No write-read collision is possible: reads are blocked while prog=1.
- Width rule: prog_len is one bit wider than pc. The compare is unsigned with pc zero-extended.

Decomposition:
- Shared package ctrl_pkg holds:
  - the INSTR_WIDTH derivation function;
  - instruction field offset localparams (last-stage flag, upsample flag, vector id, result/error logic, data_uptr, data_lptr, coef_ptr), which ctrl_ifetch also uses;
  - the loader state enum (IDLE, LOAD, DRAIN, DONE).
- One sub-module: ctrl_imem_ram, a simple dual-port RAM with a synchronous write port and a registered read port with read enable. The FSM, counters and status stay in ctrl_imem_loader.

Test Plan:
- Reset mid-load: assert rst_n=0 after 3 words -> all status outputs 0, ld_ready 0, state IDLE; a following prog rise loads cleanly.
- Basic load/fetch: prog rise, 5 words 0x000001..0x000005 with ld_last on the 5th, prog=0 -> prog_len=5, prog_valid=1. Then fetch pc=2 -> instr_word=0x000003 one cycle later, and holds while fetch=0.
- Backpressure/idle gaps: ld_valid toggled 1,0,1,1 for 3 words plus last -> exactly 4 writes, prog_len=4, no duplicates.
- Full depth: 16 words with ld_last on the 16th -> prog_len=16, prog_err=0. A second run of 17 words -> prog_err=1, prog_valid=0, state DRAIN until ld_last, then IDLE.
- Abort: prog falls after 2 words -> prog_err=1, prog_valid=0. Then fetch pc=0 -> instr_word=0, fetch_oob=1.
- Out of range and reload: with prog_len=5, fetch pc=7 -> instr_word=0, fetch_oob=1. A new prog rise clears fetch_oob and prog_err in that cycle.
